// File: rtl/adc_capture_pkg.sv
// Shared types for the X/Y ADC capture controller: FSM state encoding and memory word packing.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
//
// Contents
//   ADC_*_BITS   default widths used by the controller parameters and by the word packing
//   cap_state_e  capture sequencer states
//   xy_word_t    one memory word, X in the upper half, Y in the lower half
//   pack_xy()    builds an xy_word_t from a sample pair
package adc_capture_pkg;

  localparam int ADC_DATA_BITS  = 10;
  localparam int ADC_ADDR_BITS  = 16;
  localparam int ADC_DECIM_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  // Memory word layout. X occupies the upper bits so a flat read-back is {x, y}.
  typedef struct packed {
    logic [ADC_DATA_BITS-1:0] x;
    logic [ADC_DATA_BITS-1:0] y;
  } xy_word_t;

  function automatic xy_word_t pack_xy(input logic [ADC_DATA_BITS-1:0] x,
                                       input logic [ADC_DATA_BITS-1:0] y);
    xy_word_t w;
    w.x = x;
    w.y = y;
    return w;
  endfunction

endpackage

// File: rtl/adc_trig_detect.sv
// Rising-crossing trigger on the X channel: fires when the previous X was below level and the current X is at or above it.
// Latency: trig is combinational on the current sample; prev_x updates on the edge the sample is taken.
// Backpressure: none; sample_vld must already be the stream accept qualifier.
//
// Ports
//   clk, reset_n  clock and synchronous active-low reset
//   clear         forget the previous sample (first sample after clear can never trigger)
//   sample_vld    a sample is being accepted this cycle while armed
//   x             current X sample
//   level         unsigned trigger threshold
//   trig          crossing detected on this accepted sample
module adc_trig_detect #(
  parameter int DATA_BITS = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 sample_vld,
  input  logic [DATA_BITS-1:0] x,
  input  logic [DATA_BITS-1:0] level,
  output logic                 trig
);

  logic [DATA_BITS-1:0] prev_x_q;
  logic                 prev_x_vld_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_x_q     <= '0;
      prev_x_vld_q <= 1'b0;
    end else if (clear) begin
      prev_x_vld_q <= 1'b0;
    end else if (sample_vld) begin
      prev_x_q     <= x;
      prev_x_vld_q <= 1'b1;
    end
  end

  assign trig = sample_vld && prev_x_vld_q && (prev_x_q < level) && (x >= level);

endmodule

// File: rtl/adc_xy_capture_ctrl.sv
// Single-shot capture of a decimated X/Y ADC stream into sample memory, with optional rising-edge X trigger.
// Latency: kept sample accepted at edge k drives m_wr_valid from edge k+1; trigger sample moves to CAPTURE next edge.
// Backpressure: one-entry write register; in CAPTURE s_tready = !m_wr_valid || m_wr_ready, and 0 once the last sample is kept.
//
// Ports
//   clk, reset_n          clock and synchronous active-low reset (overrides start/abort)
//   start, abort          command pulses; abort wins over start, start only honoured in IDLE/DONE
//   cfg_*                 capture configuration, latched on the accepted start
//   s_tvalid/s_tready     ADC stream handshake, s_adc_x/s_adc_y sample pair
//   m_wr_valid/m_wr_ready memory write handshake, m_wr_addr/m_wr_data = address and {x, y}
//   busy, done            status: ARMED or CAPTURE / in DONE
module adc_xy_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int DATA_BITS  = ADC_DATA_BITS,
  parameter int ADDR_BITS  = ADC_ADDR_BITS,
  parameter int DECIM_BITS = ADC_DECIM_BITS
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DECIM_BITS-1:0]  cfg_decim,
  input  logic [ADDR_BITS:0]     cfg_count,
  input  logic                   cfg_trig_en,
  input  logic [DATA_BITS-1:0]   cfg_trig_level,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [DATA_BITS-1:0]   s_adc_x,
  input  logic [DATA_BITS-1:0]   s_adc_y,
  output logic                   m_wr_valid,
  input  logic                   m_wr_ready,
  output logic [ADDR_BITS-1:0]   m_wr_addr,
  output logic [2*DATA_BITS-1:0] m_wr_data,
  output logic                   busy,
  output logic                   done
);

  // The count field is one bit wider than the address so a full-depth request fits.
  localparam logic [ADDR_BITS:0]    FULL_DEPTH = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0]    CNT_ONE    = (ADDR_BITS+1)'(1);
  localparam logic [DECIM_BITS-1:0] DEC_ONE    = DECIM_BITS'(1);

  cap_state_e state_q;
  cap_state_e state_d;

  // Latched configuration
  logic [DECIM_BITS-1:0] decim_q;
  logic [ADDR_BITS:0]    count_q;
  logic [DATA_BITS-1:0]  level_q;

  // Capture progress
  logic [ADDR_BITS:0]    kept_cnt_q;   // samples kept so far; also the address of the next kept sample
  logic [DECIM_BITS-1:0] decim_cnt_q;  // 0 means the next capture accept is kept

  // One-entry write output register
  logic                  wr_vld_q;
  logic [ADDR_BITS-1:0]  wr_addr_q;
  xy_word_t              wr_dat_q;

  logic [ADDR_BITS:0]    cfg_count_sat;
  logic                  start_acc;
  logic                  accept;
  logic                  all_kept;
  logic                  wr_acc;
  logic                  armed_sample;
  logic                  trig_hit;
  logic                  cap_accept;
  logic                  cap_keep;
  logic                  keep;
  logic                  last_wr_done;

  assign cfg_count_sat = (cfg_count > FULL_DEPTH) ? FULL_DEPTH : cfg_count;

  assign start_acc    = start && !abort && (state_q == ST_IDLE || state_q == ST_DONE);
  assign accept       = s_tvalid && s_tready;
  assign all_kept     = (kept_cnt_q == count_q);
  assign wr_acc       = wr_vld_q && m_wr_ready;
  assign armed_sample = accept && (state_q == ST_ARMED);
  assign cap_accept   = accept && (state_q == ST_CAPTURE);
  assign cap_keep     = cap_accept && (decim_cnt_q == '0);
  // The trigger sample itself is the first stored word.
  assign keep         = cap_keep || trig_hit;
  // Once everything is kept, the only outstanding write is the final one.
  assign last_wr_done = (state_q == ST_CAPTURE) && wr_acc && all_kept;

  adc_trig_detect #(
    .DATA_BITS (DATA_BITS)
  ) u_trig (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (start_acc),
    .sample_vld (armed_sample),
    .x          (s_adc_x),
    .level      (level_q),
    .trig       (trig_hit)
  );

  // ---------------------------------------------------------------- FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- FSM next state
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (cfg_count_sat == '0) begin
              state_d = ST_DONE;
            end else if (cfg_trig_en) begin
              state_d = ST_ARMED;
            end else begin
              state_d = ST_CAPTURE;
            end
          end
        end
        ST_ARMED: begin
          if (trig_hit) begin
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (last_wr_done) begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM outputs
  always_comb begin
    s_tready = 1'b1;   // IDLE/DONE discard, ARMED watches for the trigger
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_ARMED: begin
        busy = 1'b1;
      end
      ST_CAPTURE: begin
        busy     = 1'b1;
        s_tready = !all_kept && (!wr_vld_q || m_wr_ready);
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        s_tready = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------- config latch and progress counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      decim_q     <= '0;
      count_q     <= '0;
      level_q     <= '0;
      kept_cnt_q  <= '0;
      decim_cnt_q <= '0;
    end else if (start_acc) begin
      decim_q     <= cfg_decim;
      count_q     <= cfg_count_sat;
      level_q     <= cfg_trig_level;
      kept_cnt_q  <= '0;
      decim_cnt_q <= '0;
    end else begin
      // The decimation phase advances on every sample seen from the trigger onward.
      if (cap_accept || trig_hit) begin
        decim_cnt_q <= (decim_cnt_q == decim_q) ? '0 : decim_cnt_q + DEC_ONE;
      end
      if (keep) begin
        kept_cnt_q <= kept_cnt_q + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------- write output register
  // s_tready guarantees the register is empty or draining whenever a sample is kept,
  // so a load never overwrites an unaccepted write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_dat_q  <= '0;
    end else if (abort) begin
      wr_vld_q  <= 1'b0;
    end else if (keep) begin
      wr_vld_q  <= 1'b1;
      wr_addr_q <= kept_cnt_q[ADDR_BITS-1:0];
      wr_dat_q  <= pack_xy(s_adc_x, s_adc_y);
    end else if (wr_acc) begin
      wr_vld_q  <= 1'b0;
    end
  end

  assign m_wr_valid = wr_vld_q;
  assign m_wr_addr  = wr_addr_q;
  assign m_wr_data  = wr_dat_q;

endmodule

// File: tb/tb_adc_xy_capture_ctrl.sv
// Self-checking bench for adc_xy_capture_ctrl: directed scenarios plus randomized captures against a list-based model.
// Latency: n/a.
// Backpressure: bench drives random s_tvalid / m_wr_ready and stall windows.
module tb_adc_xy_capture_ctrl;

  localparam int DB    = 10;
  localparam int AB    = 8;
  localparam int QB    = 8;
  localparam int DEPTH = 1 << AB;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [QB-1:0] cfg_decim;
  logic [AB:0]   cfg_count;
  logic          cfg_trig_en;
  logic [DB-1:0] cfg_trig_level;
  logic          s_tvalid;
  logic          s_tready;
  logic [DB-1:0] s_adc_x;
  logic [DB-1:0] s_adc_y;
  logic          m_wr_valid;
  logic          m_wr_ready;
  logic [AB-1:0] m_wr_addr;
  logic [2*DB-1:0] m_wr_data;
  logic          busy;
  logic          done;

  adc_xy_capture_ctrl #(
    .DATA_BITS  (DB),
    .ADDR_BITS  (AB),
    .DECIM_BITS (QB)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .cfg_decim      (cfg_decim),
    .cfg_count      (cfg_count),
    .cfg_trig_en    (cfg_trig_en),
    .cfg_trig_level (cfg_trig_level),
    .s_tvalid       (s_tvalid),
    .s_tready       (s_tready),
    .s_adc_x        (s_adc_x),
    .s_adc_y        (s_adc_y),
    .m_wr_valid     (m_wr_valid),
    .m_wr_ready     (m_wr_ready),
    .m_wr_addr      (m_wr_addr),
    .m_wr_data      (m_wr_data),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Observed traffic of the current capture
  int acc_x[$];
  int acc_y[$];
  int acc_cyc[$];
  int wr_addr_l[$];
  int wr_data_l[$];
  int first_vld_cyc;
  int src_x;
  int src_y;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arms one capture, streams until done (bounded), then compares against the model:
  // the stored words are accepted samples start_i, start_i+(d+1), ... where start_i is
  // the first rising crossing (never index 0) or 0 without trigger.
  task automatic run_capture(input int decim, input int count, input int trig_en, input int level,
                             input int vld_pct, input int rdy_pct, input int mode,
                             input int x0, input int xstep, input int stall_at);
    int   n;
    int   cnt_sat;
    int   start_i;
    int   last_i;
    int   idx;
    logic prev_stall;
    int   prev_addr;
    int   prev_data;

    acc_x.delete(); acc_y.delete(); acc_cyc.delete();
    wr_addr_l.delete(); wr_data_l.delete();
    first_vld_cyc = -1;
    prev_stall    = 1'b0;
    prev_addr     = 0;
    prev_data     = 0;
    src_x = (mode == 0) ? x0 : int'($urandom_range(1023));
    src_y = int'($urandom_range(1023));

    cfg_decim      = QB'(decim);
    cfg_count      = (AB+1)'(count);
    cfg_trig_en    = trig_en[0];
    cfg_trig_level = DB'(level);
    s_tvalid       = 1'b0;
    m_wr_ready     = 1'b1;
    start          = 1'b1;
    step();
    start = 1'b0;
    // Config must have been latched; scramble it for the rest of the run.
    cfg_decim      = QB'($urandom);
    cfg_count      = (AB+1)'($urandom);
    cfg_trig_en    = 1'($urandom);
    cfg_trig_level = DB'($urandom);

    n = 0;
    while (!done && n < 4000) begin
      s_tvalid   = (int'($urandom_range(99)) < vld_pct);
      s_adc_x    = DB'(src_x);
      s_adc_y    = DB'(src_y);
      if (stall_at >= 0 && n >= stall_at && n < stall_at + 5)
        m_wr_ready = 1'b0;
      else
        m_wr_ready = (int'($urandom_range(99)) < rdy_pct);
      start = ($urandom_range(7) == 0);  // must be ignored while busy
      @(negedge clk);
      if (prev_stall) begin
        check("hold_vld", 32'(m_wr_valid), 1);
        check("hold_addr", 32'(m_wr_addr), prev_addr);
        check("hold_data", 32'(m_wr_data), prev_data);
      end
      if (m_wr_valid && !m_wr_ready) check("stall_tready", 32'(s_tready), 0);
      if (m_wr_valid && first_vld_cyc < 0) first_vld_cyc = n;
      if (m_wr_valid && m_wr_ready) begin
        wr_addr_l.push_back(int'(m_wr_addr));
        wr_data_l.push_back(int'(m_wr_data));
      end
      if (s_tvalid && s_tready) begin
        acc_x.push_back(src_x);
        acc_y.push_back(src_y);
        acc_cyc.push_back(n);
        src_x = (mode == 0) ? ((src_x + xstep) & 1023) : int'($urandom_range(1023));
        src_y = int'($urandom_range(1023));
      end
      prev_stall = m_wr_valid && !m_wr_ready;
      prev_addr  = int'(m_wr_addr);
      prev_data  = int'(m_wr_data);
      step();
      n++;
    end
    start      = 1'b0;
    s_tvalid   = 1'b0;
    m_wr_ready = 1'b1;

    check("done_in_budget", 32'(done), 1);
    check("busy_at_done", 32'(busy), 0);

    cnt_sat = (count > DEPTH) ? DEPTH : count;
    start_i = 0;
    if (trig_en != 0) begin
      start_i = -1;
      for (int i = 1; i < acc_x.size(); i++) begin
        if (acc_x[i-1] < level && acc_x[i] >= level) begin
          start_i = i;
          break;
        end
      end
    end
    check("trigger_found", 32'(start_i >= 0), 1);
    check("write_count", wr_addr_l.size(), cnt_sat);
    if (start_i >= 0) begin
      last_i = start_i + (cnt_sat - 1) * (decim + 1);
      check("accept_total", acc_x.size(), last_i + 1);
      check("first_latency", first_vld_cyc, acc_cyc[start_i] + 1);
      for (int j = 0; j < wr_addr_l.size() && j < cnt_sat; j++) begin
        idx = start_i + j * (decim + 1);
        check("wr_addr", wr_addr_l[j], j);
        if (idx < acc_x.size())
          check("wr_data", wr_data_l[j], (acc_x[idx] << DB) | acc_y[idx]);
        else
          check("wr_data_src", idx, acc_x.size() - 1);
      end
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    start          = 1'b1;   // reset must override start
    abort          = 1'b0;
    cfg_decim      = '0;
    cfg_count      = (AB+1)'(4);
    cfg_trig_en    = 1'b0;
    cfg_trig_level = '0;
    s_tvalid       = 1'b1;
    s_adc_x        = '0;
    s_adc_y        = '0;
    m_wr_ready     = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wr_valid", 32'(m_wr_valid), 0);
    check("rst_addr", 32'(m_wr_addr), 0);
    check("rst_tready", 32'(s_tready), 1);
    reset_n = 1'b1;
    start   = 1'b0;
    s_tvalid = 1'b0;
    step();

    // 1: immediate capture of a ramp
    run_capture(0, 4, 0, 0, 100, 100, 0, 1, 1, -1);
    if (wr_data_l.size() == 4) begin
      check("t1_first_x", (wr_data_l[0] >> DB) & 1023, 1);
      check("t1_last_x", (wr_data_l[3] >> DB) & 1023, 4);
    end else check("t1_writes", wr_data_l.size(), 4);

    // 2: trigger at 512 on a ramp 500, 504, ...
    run_capture(0, 4, 1, 512, 100, 100, 0, 500, 4, -1);
    if (wr_data_l.size() > 0) check("t2_first_x", (wr_data_l[0] >> DB) & 1023, 512);
    else check("t2_writes", wr_data_l.size(), 4);

    // 3: decimation by 3
    run_capture(2, 3, 0, 0, 100, 100, 0, 10, 1, -1);
    if (wr_data_l.size() == 3) check("t3_last_x", (wr_data_l[2] >> DB) & 1023, 16);
    else check("t3_writes", wr_data_l.size(), 3);

    // 4: five-cycle write stall mid-capture
    run_capture(1, 12, 0, 0, 100, 100, 0, 100, 3, 3);

    // 5: abort with a stalled write
    cfg_decim = '0; cfg_count = (AB+1)'(10); cfg_trig_en = 1'b0;
    m_wr_ready = 1'b0; s_tvalid = 1'b0; start = 1'b1;
    step();
    start = 1'b0; s_tvalid = 1'b1; s_adc_x = DB'(7);
    repeat (3) step();
    @(negedge clk);
    check("ab_pre_vld", 32'(m_wr_valid), 1);
    check("ab_pre_tready", 32'(s_tready), 0);
    check("ab_pre_busy", 32'(busy), 1);
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("ab_vld", 32'(m_wr_valid), 0);
    check("ab_busy", 32'(busy), 0);
    check("ab_done", 32'(done), 0);
    check("ab_tready", 32'(s_tready), 1);
    // start and abort together in IDLE: abort wins
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    check("ab_start_busy", 32'(busy), 0);
    check("ab_start_done", 32'(done), 0);
    m_wr_ready = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check("ab_no_write", 32'(m_wr_valid), 0);
    s_tvalid = 1'b0;

    // reset mid-capture with start held
    cfg_count = (AB+1)'(6); m_wr_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0; s_tvalid = 1'b1;
    repeat (2) step();
    reset_n = 1'b0; start = 1'b1;
    step();
    @(negedge clk);
    check("mrst_vld", 32'(m_wr_valid), 0);
    check("mrst_busy", 32'(busy), 0);
    reset_n = 1'b1; start = 1'b0; s_tvalid = 1'b0; m_wr_ready = 1'b1;
    step();

    // 6: zero-length capture goes straight to DONE
    cfg_count = '0; start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    check("c0_done", 32'(done), 1);
    check("c0_busy", 32'(busy), 0);
    check("c0_vld", 32'(m_wr_valid), 0);
    step();
    @(negedge clk);
    check("c0_vld_later", 32'(m_wr_valid), 0);

    // re-arm from DONE
    run_capture(1, 5, 0, 0, 80, 80, 1, 0, 0, -1);

    // full depth and saturated count both end at the all-ones address
    run_capture(0, DEPTH, 0, 0, 100, 100, 0, 0, 1, -1);
    if (wr_addr_l.size() > 0) check("full_last_addr", wr_addr_l[wr_addr_l.size()-1], DEPTH - 1);
    run_capture(0, DEPTH + 44, 0, 0, 100, 100, 1, 0, 0, -1);
    if (wr_addr_l.size() > 0) check("sat_last_addr", wr_addr_l[wr_addr_l.size()-1], DEPTH - 1);

    // randomized captures
    for (int r = 0; r < 10; r++) begin
      run_capture(int'($urandom_range(3)), int'($urandom_range(20, 1)), int'($urandom_range(1)),
                  int'($urandom_range(800, 200)), int'($urandom_range(100, 50)),
                  int'($urandom_range(100, 30)), 1, 0, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
